// File: rtl/eth_frame_receiver_pkg.sv
// Shared constants, types and the CRC-32 dibit step for the dibit Ethernet
// frame receiver. Frame-level sizes, the FCS residue and the status bit
// positions live here so the receiver and anything consuming its status
// agree on them.
package eth_frame_receiver_pkg;

   // Field sizes of an Ethernet frame, in bytes
   localparam int BYTE_LEN          = 8;
   localparam int ETH_MAC_LEN       = 6;
   localparam int ETH_ETHERTYPE_LEN = 2;
   localparam int ETH_CRC_LEN       = 4;
   localparam int ETH_HDR_LEN       = 2 * ETH_MAC_LEN + ETH_ETHERTYPE_LEN;

   // Reflected CRC-32 constants; after the FCS has been folded in, a clean
   // frame always leaves the register at the fixed residue
   localparam logic [31:0] ETH_CRC_INIT    = 32'hffffffff;
   localparam logic [31:0] ETH_CRC_POLY    = 32'hedb88320;
   localparam logic [31:0] ETH_CRC_RESIDUE = 32'hdebb20e3;

   // Bit positions inside the 3-bit status word
   localparam int ETH_RX_STATUS_CRC_ERR   = 0;
   localparam int ETH_RX_STATUS_LEN_ERR   = 1;
   localparam int ETH_RX_STATUS_ALIGN_ERR = 2;

   // Dibit values with a line-level meaning
   localparam logic [1:0] DIBIT_IDLE = 2'b00;
   localparam logic [1:0] DIBIT_PRE  = 2'b01;
   localparam logic [1:0] DIBIT_SFD  = 2'b11;

   // Status word, packed so that it lines up with the ETH_RX_STATUS_* indices
   typedef struct packed {
      logic alignErr;
      logic lenErr;
      logic crcErr;
   } rxStatus_t;

   // Fold one dibit into the CRC, bit [0] first, same step as the transmitter
   function automatic logic [31:0] crc32Dibit(input logic [31:0] crc, input logic [1:0] dibit);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 2; i++) begin
         if (c[0] ^ dibit[i]) begin
            c = (c >> 1) ^ ETH_CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_frame_receiver_if.sv
// Line-side and frame-side signals of the dibit Ethernet receiver. The
// master modport is the line source / frame consumer, the slave modport is
// the receiver itself.
interface eth_frame_receiver_if;
   import eth_frame_receiver_pkg::*;

   logic                inclk;
   logic [1:0]          in;
   logic                outclk;
   logic [BYTE_LEN-1:0] out;
   logic                done;
   logic                ok;
   logic [2:0]          status;

   modport master (
      output inclk,
      output in,
      input  outclk,
      input  out,
      input  done,
      input  ok,
      input  status
   );

   modport slave (
      input  inclk,
      input  in,
      output outclk,
      output out,
      output done,
      output ok,
      output status
   );

endinterface

// File: rtl/eth_frame_receiver_holdback.sv
// FCS holdback for the frame receiver: a 4-entry byte shift FIFO. Bytes are
// only released once four newer bytes sit behind them, so the trailing FCS
// is still inside the FIFO when the carrier drops and is never forwarded.
module eth_rx_fcs_holdback
   import eth_frame_receiver_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear_i,
   input  logic                push_i,
   input  logic [BYTE_LEN-1:0] data_i,
   output logic                emit_o,
   output logic [BYTE_LEN-1:0] emitData_o
);

   localparam int DEPTH = ETH_CRC_LEN;

   logic [BYTE_LEN-1:0] slot_q [DEPTH];
   logic [2:0]          count_q;
   logic [2:0]          count_d;
   logic                full;

   // The oldest byte leaves exactly when a new one arrives into a full FIFO
   assign full       = (count_q == 3'(DEPTH));
   assign emit_o     = push_i && full;
   assign emitData_o = slot_q[DEPTH-1];

   // Occupancy saturates at the FIFO depth; a new frame starts empty
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (push_i && !full) begin
         count_d = count_q + 3'd1;
      end
   end

   // Newest byte enters slot 0, older bytes ripple towards the output slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push_i && !clear_i) begin
            slot_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
               slot_q[i] <= slot_q[i-1];
            end
         end
      end
   end

endmodule

// File: rtl/eth_frame_receiver.sv
// Receive side of the dibit Ethernet link. Hunts for preamble/SFD on the
// RMII-style dibit stream, rebuilds bytes LSB first, forwards dst MAC
// through payload (FCS held back and stripped), checks CRC-32, length and
// byte alignment and pulses done with ok/status at the end of each frame.
// Build option: define ETH_RX_STRIP_HEADER_EN to also suppress the 14
// header bytes so that only payload bytes are strobed out; CRC and length
// checks still cover the whole frame.
module eth_frame_receiver
   import eth_frame_receiver_pkg::*;
#(
   parameter int MAX_FRAME_LEN = 1518,
   parameter int MIN_FRAME_LEN = 64,
   parameter int PREAMBLE_MIN  = 8
) (
   input  logic clk,
   input  logic rst,
   eth_frame_receiver_if.slave bus
);

   localparam logic [2:0] WAIT_IDLE = 3'd0;
   localparam logic [2:0] IDLE      = 3'd1;
   localparam logic [2:0] PREAMBLE  = 3'd2;
   localparam logic [2:0] BODY      = 3'd3;
   localparam logic [2:0] DROP      = 3'd4;

   logic [2:0]          state_q,   state_d;
   logic [5:0]          preCnt_q,  preCnt_d;
   logic [31:0]         crc_q,     crc_d;
   logic [10:0]         byteCnt_q, byteCnt_d;
   logic [1:0]          phase_q,   phase_d;
   logic [5:0]          shift_q,   shift_d;
   logic                lenErr_q,  lenErr_d;
   logic                outclk_q,  outclk_d;
   logic [BYTE_LEN-1:0] out_q,     out_d;
   logic                done_q,    done_d;
   logic                ok_q,      ok_d;
   rxStatus_t           status_q,  status_d;

   logic [10:0]         byteCntInc;
   logic [BYTE_LEN-1:0] newByte;
   logic                lenErrNow;
   logic                stripPass;
   logic                hbClear;
   logic                hbPush;
   logic                hbEmit;
   logic [BYTE_LEN-1:0] hbEmitData;

   // Byte count as it stands once the current dibit completes a byte,
   // saturating at the counter's full scale
   assign byteCntInc = (byteCnt_q == '1) ? byteCnt_q : byteCnt_q + 11'd1;
   assign newByte    = {bus.in, shift_q};
   assign lenErrNow  = lenErr_q || (int'(byteCntInc) > MAX_FRAME_LEN);
   assign hbPush     = (state_q == BODY) && bus.inclk && (phase_q == 2'd3);

   // The byte released now is frame byte (byteCntInc - 5); header bytes are
   // those with index below ETH_HDR_LEN
`ifdef ETH_RX_STRIP_HEADER_EN
   assign stripPass = (int'(byteCntInc) > ETH_HDR_LEN + ETH_CRC_LEN);
`else
   assign stripPass = 1'b1;
`endif

   eth_rx_fcs_holdback u_holdback (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (hbClear),
      .push_i     (hbPush),
      .data_i     (newByte),
      .emit_o     (hbEmit),
      .emitData_o (hbEmitData)
   );

   // Frame state machine: preamble hunt, byte assembly, CRC fold and the
   // end-of-frame verdict, all decided from the current line dibit
   always_comb begin
      state_d   = state_q;
      preCnt_d  = preCnt_q;
      crc_d     = crc_q;
      byteCnt_d = byteCnt_q;
      phase_d   = phase_q;
      shift_d   = shift_q;
      lenErr_d  = lenErr_q;
      outclk_d  = 1'b0;
      out_d     = out_q;
      done_d    = 1'b0;
      ok_d      = ok_q;
      status_d  = status_q;
      hbClear   = 1'b0;
      case (state_q)
         WAIT_IDLE: begin
            if (!bus.inclk) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (bus.inclk) begin
               if (bus.in == DIBIT_PRE) begin
                  state_d  = PREAMBLE;
                  preCnt_d = 6'd1;
               end else if (bus.in != DIBIT_IDLE) begin
                  state_d = DROP;
               end
            end
         end
         PREAMBLE: begin
            if (!bus.inclk) begin
               state_d = IDLE;
            end else if (bus.in == DIBIT_PRE) begin
               if (preCnt_q != '1) begin
                  preCnt_d = preCnt_q + 6'd1;
               end
            end else if ((bus.in == DIBIT_SFD) && (int'(preCnt_q) >= PREAMBLE_MIN)) begin
               state_d   = BODY;
               crc_d     = ETH_CRC_INIT;
               byteCnt_d = '0;
               phase_d   = '0;
               shift_d   = '0;
               lenErr_d  = 1'b0;
               hbClear   = 1'b1;
               ok_d      = 1'b0;
               status_d  = '0;
            end else begin
               state_d = DROP;
            end
         end
         BODY: begin
            if (bus.inclk) begin
               crc_d   = crc32Dibit(crc_q, bus.in);
               shift_d = {bus.in, shift_q[5:2]};
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd3) begin
                  byteCnt_d = byteCntInc;
                  lenErr_d  = lenErrNow;
                  if (hbEmit && !lenErrNow && stripPass) begin
                     outclk_d = 1'b1;
                     out_d    = hbEmitData;
                  end
               end
            end else begin
               status_d.alignErr = (phase_q != 2'd0);
               status_d.lenErr   = lenErr_q
                                   || (int'(byteCnt_q) < MIN_FRAME_LEN)
                                   || (int'(byteCnt_q) > MAX_FRAME_LEN);
               status_d.crcErr   = (crc_q != ETH_CRC_RESIDUE);
               ok_d              = (status_d == '0);
               done_d            = 1'b1;
               state_d           = IDLE;
            end
         end
         DROP: begin
            if (!bus.inclk) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any frame in flight and
   // waits for a quiet line before hunting again
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= WAIT_IDLE;
         preCnt_q  <= '0;
         crc_q     <= ETH_CRC_INIT;
         byteCnt_q <= '0;
         phase_q   <= '0;
         shift_q   <= '0;
         lenErr_q  <= 1'b0;
         outclk_q  <= 1'b0;
         out_q     <= '0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         status_q  <= '0;
      end else begin
         state_q   <= state_d;
         preCnt_q  <= preCnt_d;
         crc_q     <= crc_d;
         byteCnt_q <= byteCnt_d;
         phase_q   <= phase_d;
         shift_q   <= shift_d;
         lenErr_q  <= lenErr_d;
         outclk_q  <= outclk_d;
         out_q     <= out_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         status_q  <= status_d;
      end
   end

   assign bus.outclk = outclk_q;
   assign bus.out    = out_q;
   assign bus.done   = done_q;
   assign bus.ok     = ok_q;
   assign bus.status = status_q;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Bench for eth_frame_receiver: directed frames on the dibit line, a
// frame-level model (bit-serial CRC over the frame as sent, byte and dibit
// counts) filling an expected byte queue and verdict, and one compare
// process that checks every strobed byte and every done pulse.
`timescale 1ns/1ps
module tb_eth_frame_receiver;
   import eth_frame_receiver_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   eth_frame_receiver_if bus ();

   eth_frame_receiver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          testsRun    = 0;
   int          testsFailed = 0;
   int          outCount    = 0;
   int          doneCount   = 0;
   int          expCount    = 0;
   bit          doneArmed   = 1'b0;
   logic        expOk       = 1'b0;
   logic [2:0]  expStatus   = 3'b000;
   logic [7:0]  expQ [$];
   logic [7:0]  frame [$];

   // Single comparison with pass/fail bookkeeping
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      testsRun++;
      if (actual !== required) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
      end
   endtask

   // Comparison that has already gone wrong (nothing to set against)
   task automatic reportFail(input string name, input string detail);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: %s", name, detail);
   endtask

   // Checks every strobed byte and every done pulse against the model
   always @(negedge clk) begin
      if (bus.outclk === 1'b1) begin
         outCount++;
         if (expQ.size() == 0) begin
            reportFail("outByte", $sformatf("got byte %02h, none required", bus.out));
         end else begin
            checkOutput("outByte", {24'd0, bus.out}, {24'd0, expQ.pop_front()});
         end
      end
      if (bus.done === 1'b1) begin
         if (!doneArmed) begin
            reportFail("done", "got done pulse, none required");
         end else begin
            checkOutput("ok", {31'd0, bus.ok}, {31'd0, expOk});
            checkOutput("status", {29'd0, bus.status}, {29'd0, expStatus});
            doneArmed = 1'b0;
            doneCount++;
         end
      end
   end

   // Reference CRC register over a bit sequence, bits in line order
   function automatic logic [31:0] crcOfBits(input bit b[$]);
      logic [31:0] c;
      logic        fb;
      c = 32'hffffffff;
      foreach (b[i]) begin
         fb = c[0] ^ b[i];
         c  = c >> 1;
         if (fb) c = c ^ 32'hedb88320;
      end
      return c;
   endfunction

   // Appends the FCS (complemented CRC, low byte first) to the frame
   task automatic appendFcs();
      bit          b [$];
      logic [31:0] fcs;
      foreach (frame[i]) for (int j = 0; j < 8; j++) b.push_back(frame[i][j]);
      fcs = ~crcOfBits(b);
      for (int j = 0; j < 4; j++) frame.push_back(fcs[8*j +: 8]);
   endtask

   // Broadcast test frame truncated to dataLen bytes, plus a valid FCS
   task automatic buildFrame(input int dataLen);
      frame.delete();
      for (int i = 0; i < 6; i++) frame.push_back(8'hff);
      frame.push_back(8'h02);
      for (int i = 0; i < 4; i++) frame.push_back(8'h00);
      frame.push_back(8'h01);
      frame.push_back(8'h00);
      frame.push_back(8'h00);
      for (int i = 0; i < 46; i++) frame.push_back(8'h00);
      while (frame.size() > dataLen) void'(frame.pop_back());
      appendFcs();
   endtask

   // Frame-level model: which bytes must appear and what verdict follows
   task automatic modelFrame(input int extraDibits);
      bit          b [$];
      int          n;
      logic [31:0] crcReg;
      n = frame.size();
      foreach (frame[i]) for (int j = 0; j < 8; j++) b.push_back(frame[i][j]);
      for (int e = 0; e < extraDibits; e++) begin
         b.push_back(1'b1);
         b.push_back(1'b0);
      end
      crcReg = crcOfBits(b);
      expStatus = 3'b000;
      expStatus[ETH_RX_STATUS_ALIGN_ERR] = (b.size() % 8) != 0;
      expStatus[ETH_RX_STATUS_LEN_ERR]   = (n < 64) || (n > 1518);
      expStatus[ETH_RX_STATUS_CRC_ERR]   = (crcReg != 32'hdebb20e3);
      expOk    = (expStatus == 3'b000);
      expCount = 0;
      for (int k = 0; k + 4 < n; k++) begin
`ifdef ETH_RX_STRIP_HEADER_EN
         if (k < 14) continue;
`endif
         expQ.push_back(frame[k]);
         expCount++;
      end
   endtask

   // One dibit on the line with carrier high
   task automatic applyStimulus(input logic [1:0] d);
      @(posedge clk);
      #1;
      bus.inclk = 1'b1;
      bus.in    = d;
   endtask

   task automatic driveByte(input logic [7:0] b);
      for (int j = 0; j < 4; j++) applyStimulus(b[2*j +: 2]);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.inclk = 1'b0;
         bus.in    = 2'b00;
      end
   endtask

   // Sends preamble, SFD, the current frame and optional stray dibits, then
   // drops carrier and checks done timing, byte count and held verdict
   task automatic sendFrame(input int preLen, input int extraDibits, input bit expectFrame, input string name);
      int startOut;
      int startDone;
      startOut  = outCount;
      startDone = doneCount;
      if (expectFrame) begin
         modelFrame(extraDibits);
         doneArmed = 1'b1;
      end
      for (int i = 0; i < preLen; i++) applyStimulus(DIBIT_PRE);
      applyStimulus(DIBIT_SFD);
      foreach (frame[i]) driveByte(frame[i]);
      for (int e = 0; e < extraDibits; e++) applyStimulus(2'b01);
      @(posedge clk);
      #1;
      bus.inclk = 1'b0;
      bus.in    = 2'b00;
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, "_doneAtLatency"}, {31'd0, bus.done}, expectFrame ? 32'd1 : 32'd0);
      idleCycles(4);
      checkOutput({name, "_doneCount"}, doneCount - startDone, expectFrame ? 32'd1 : 32'd0);
      checkOutput({name, "_byteCount"}, outCount - startOut, expectFrame ? expCount : 0);
      checkOutput({name, "_pending"}, expQ.size(), 0);
      if (expectFrame) begin
         checkOutput({name, "_verdictHeld"}, {28'd0, bus.ok, bus.status}, {28'd0, expOk, expStatus});
      end
   endtask

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      testsFailed++;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      string       s;
      bit          b [$];
      int          startOut;
      int          startDone;

      bus.inclk = 1'b0;
      bus.in    = 2'b00;
      #2 rst = 1'b0;

      // Reset state
      @(negedge clk);
      checkOutput("rst_outclk", {31'd0, bus.outclk}, 32'd0);
      checkOutput("rst_out", {24'd0, bus.out}, 32'd0);
      checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
      checkOutput("rst_ok", {31'd0, bus.ok}, 32'd0);
      checkOutput("rst_status", {29'd0, bus.status}, 32'd0);

      // Pin the CRC model against the published check value
      s = "123456789";
      for (int i = 0; i < s.len(); i++) for (int j = 0; j < 8; j++) b.push_back(s[i][j]);
      checkOutput("model_crcCheckValue", ~crcOfBits(b), 32'hcbf43926);

      @(posedge clk);
      #1 rst = 1'b1;
      idleCycles(3);

      // Good minimum-size frame
      buildFrame(60);
      b.delete();
      foreach (frame[i]) for (int j = 0; j < 8; j++) b.push_back(frame[i][j]);
      checkOutput("model_residue", crcOfBits(b), 32'hdebb20e3);
      sendFrame(31, 0, 1'b1, "good");
      checkOutput("good_verdictLiteral", {28'd0, expOk, expStatus}, 32'h8);
`ifdef ETH_RX_STRIP_HEADER_EN
      checkOutput("good_countLiteral", expCount, 46);
`else
      checkOutput("good_countLiteral", expCount, 60);
`endif

      // One payload bit flipped, FCS left as it was
      buildFrame(60);
      frame[20] = frame[20] ^ 8'h08;
      sendFrame(31, 0, 1'b1, "crcBad");
      checkOutput("crcBad_verdictLiteral", {28'd0, expOk, expStatus}, 32'h1);

      // Truncated to 40 bytes including a valid FCS
      buildFrame(36);
      sendFrame(31, 0, 1'b1, "short");
      checkOutput("short_verdictLiteral", {28'd0, expOk, expStatus}, 32'h2);
`ifdef ETH_RX_STRIP_HEADER_EN
      checkOutput("short_countLiteral", expCount, 22);
`else
      checkOutput("short_countLiteral", expCount, 36);
`endif

      // One stray dibit after the FCS
      buildFrame(60);
      sendFrame(31, 1, 1'b1, "extraDibit");
      checkOutput("extraDibit_alignLiteral", {31'd0, expStatus[ETH_RX_STATUS_ALIGN_ERR]}, 32'd1);
      checkOutput("extraDibit_okLiteral", {31'd0, expOk}, 32'd0);

      // Preambles too short to qualify, then the exact minimum
      buildFrame(60);
      sendFrame(4, 0, 1'b0, "pre4");
      sendFrame(7, 0, 1'b0, "pre7");
      sendFrame(8, 0, 1'b1, "pre8");
      checkOutput("pre8_okLiteral", {31'd0, expOk}, 32'd1);

      // Reset in the middle of the payload with carrier still up
      buildFrame(60);
      for (int k = 0; k < 26; k++) begin
`ifdef ETH_RX_STRIP_HEADER_EN
         if (k < 14) continue;
`endif
         expQ.push_back(frame[k]);
      end
      startOut  = outCount;
      startDone = doneCount;
      for (int i = 0; i < 31; i++) applyStimulus(DIBIT_PRE);
      applyStimulus(DIBIT_SFD);
      for (int i = 0; i < 30; i++) driveByte(frame[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstMid_strobeBefore", {31'd0, bus.outclk}, 32'd1);
      #1 rst = 1'b0;
      #1;
      checkOutput("rstMid_outclk", {31'd0, bus.outclk}, 32'd0);
      checkOutput("rstMid_out", {24'd0, bus.out}, 32'd0);
      checkOutput("rstMid_done", {31'd0, bus.done}, 32'd0);
      checkOutput("rstMid_okStatus", {28'd0, bus.ok, bus.status}, 32'd0);
      checkOutput("rstMid_pending", expQ.size(), 0);
      for (int i = 0; i < 3; i++) applyStimulus(DIBIT_PRE);
      #2 rst = 1'b1;
      for (int i = 30; i < frame.size(); i++) driveByte(frame[i]);
      for (int i = 0; i < 31; i++) applyStimulus(DIBIT_PRE);
      applyStimulus(DIBIT_SFD);
      for (int i = 0; i < 20; i++) driveByte(frame[i]);
      idleCycles(6);
      checkOutput("rstMid_noDone", doneCount - startDone, 0);
      checkOutput("rstMid_bytesBeforeReset", outCount - startOut, expCount == 0 ? 0 : 26 - (60 - expCount));

      // Next well-formed frame after the quiet gap
      sendFrame(31, 0, 1'b1, "afterRst");
      checkOutput("afterRst_okLiteral", {31'd0, expOk}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
